// File: rtl/gyro_calib_ctrl.sv
// Gyro bias calibration controller: averages 2^LOG2_SAMPLES samples after a settle window, then subtracts the bias from every sample.
// Latency: corrected sample appears one cycle after each sample_valid_in strobe; the bias updates one cycle after the last accumulated sample.
// Backpressure: none; every strobe is consumed, and cal_start_in is ignored only in the single DIVIDE cycle.
//
// Ports:
//   clk_in, rst_n_in              clock and asynchronous active-low reset
//   sample_valid_in, g[xyz]_in    raw signed 16-bit gyro samples with one-cycle strobe
//   cal_start_in                  one-cycle (re)start of calibration
//   g[xyz]_out, valid_out         bias-corrected, saturated samples with one-cycle strobe
//   busy_out                      high while a calibration is in progress
//   cal_done_out                  high while a valid bias is loaded
//
// Optional build macro: GYRO_DEADBAND_EN forces corrected values with |value| < DEADBAND to zero.

module gyro_calib_ctrl #(
    parameter int LOG2_SAMPLES   = 8,
    parameter int SETTLE_SAMPLES = 16,
    parameter int DEADBAND       = 4
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               sample_valid_in,
    input  logic signed [15:0] gx_in,
    input  logic signed [15:0] gy_in,
    input  logic signed [15:0] gz_in,
    input  logic               cal_start_in,
    output logic signed [15:0] gx_out,
    output logic signed [15:0] gy_out,
    output logic signed [15:0] gz_out,
    output logic               valid_out,
    output logic               busy_out,
    output logic               cal_done_out
);

    localparam int AW = 16 + LOG2_SAMPLES;
    localparam int CW = LOG2_SAMPLES + 1;
    localparam int SW = $clog2(SETTLE_SAMPLES + 2);
    localparam logic [CW-1:0] SAMPLE_LAST = CW'((1 << LOG2_SAMPLES) - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_SAMPLES > 0) ? SETTLE_SAMPLES - 1 : 0);

    typedef enum logic [2:0] {IDLE, SETTLE, ACCUM, DIVIDE, RUN} state_t;

    state_t                 state;
    logic [SW-1:0]          settle_cnt;
    logic [CW-1:0]          sample_cnt;
    logic signed [AW-1:0]   acc_x, acc_y, acc_z;
    logic signed [15:0]     bias_x, bias_y, bias_z;

    // Subtract at 17 bits so the full-range difference is representable, then clamp.
    function automatic logic signed [15:0] correct(input logic signed [15:0] raw,
                                                   input logic signed [15:0] bias);
        logic signed [16:0] diff;
        logic signed [15:0] sat;
        diff = {raw[15], raw} - {bias[15], bias};
        if (diff[16] != diff[15]) begin
            sat = diff[16] ? 16'sh8000 : 16'sh7FFF;
        end else begin
            sat = diff[15:0];
        end
`ifdef GYRO_DEADBAND_EN
        if (int'(sat) > -DEADBAND && int'(sat) < DEADBAND) begin
            sat = '0;
        end
`else
`endif
        return sat;
    endfunction

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state        <= IDLE;
            settle_cnt   <= '0;
            sample_cnt   <= '0;
            acc_x        <= '0;
            acc_y        <= '0;
            acc_z        <= '0;
            bias_x       <= '0;
            bias_y       <= '0;
            bias_z       <= '0;
            gx_out       <= '0;
            gy_out       <= '0;
            gz_out       <= '0;
            valid_out    <= 1'b0;
            busy_out     <= 1'b0;
            cal_done_out <= 1'b0;
        end else begin
            // Correction runs in every state using the bias held before this edge,
            // so samples landing in DIVIDE still see the previous bias.
            valid_out <= sample_valid_in;
            if (sample_valid_in) begin
                gx_out <= correct(gx_in, bias_x);
                gy_out <= correct(gy_in, bias_y);
                gz_out <= correct(gz_in, bias_z);
            end

            case (state)
                DIVIDE: begin
                    // Arithmetic shift floors toward minus infinity; the mean always fits 16 bits.
                    bias_x       <= 16'(acc_x >>> LOG2_SAMPLES);
                    bias_y       <= 16'(acc_y >>> LOG2_SAMPLES);
                    bias_z       <= 16'(acc_z >>> LOG2_SAMPLES);
                    cal_done_out <= 1'b1;
                    busy_out     <= 1'b0;
                    state        <= RUN;
                end
                default: begin
                    if (cal_start_in) begin
                        // Restart beats a coincident sample: it is neither settled nor accumulated.
                        state        <= SETTLE;
                        settle_cnt   <= '0;
                        sample_cnt   <= '0;
                        acc_x        <= '0;
                        acc_y        <= '0;
                        acc_z        <= '0;
                        cal_done_out <= 1'b0;
                        busy_out     <= 1'b1;
                    end else begin
                        case (state)
                            SETTLE: begin
                                if (SETTLE_SAMPLES == 0) begin
                                    state <= ACCUM;
                                end else if (sample_valid_in) begin
                                    if (settle_cnt == SETTLE_LAST) begin
                                        state <= ACCUM;
                                    end else begin
                                        settle_cnt <= settle_cnt + 1'b1;
                                    end
                                end
                            end
                            ACCUM: begin
                                if (sample_valid_in) begin
                                    acc_x <= acc_x + AW'(gx_in);
                                    acc_y <= acc_y + AW'(gy_in);
                                    acc_z <= acc_z + AW'(gz_in);
                                    if (sample_cnt == SAMPLE_LAST) begin
                                        state <= DIVIDE;
                                    end else begin
                                        sample_cnt <= sample_cnt + 1'b1;
                                    end
                                end
                            end
                            default: begin
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gyro_calib_ctrl.sv
// Self-checking bench for gyro_calib_ctrl (LOG2_SAMPLES=2, SETTLE_SAMPLES=2, DEADBAND=4).
// Fixed vector table, directed corner sequences, then randomized traffic against a sample-counting reference model.
module tb_gyro_calib_ctrl;

    localparam int L  = 2;
    localparam int S  = 2;
    localparam int DB = 4;
    localparam int N  = 1 << L;

`ifdef GYRO_DEADBAND_EN
    localparam int DB_P3 = 0;
    localparam int DB_M3 = 0;
`else
    localparam int DB_P3 = 3;
    localparam int DB_M3 = -3;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               sample_valid = 1'b0;
    logic signed [15:0] gx = '0, gy = '0, gz = '0;
    logic               cal_start = 1'b0;
    logic signed [15:0] gx_o, gy_o, gz_o;
    logic               valid_o, busy_o, done_o;

    always #5 clk = ~clk;

    gyro_calib_ctrl #(
        .LOG2_SAMPLES   (L),
        .SETTLE_SAMPLES (S),
        .DEADBAND       (DB)
    ) dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .sample_valid_in (sample_valid),
        .gx_in           (gx),
        .gy_in           (gy),
        .gz_in           (gz),
        .cal_start_in    (cal_start),
        .gx_out          (gx_o),
        .gy_out          (gy_o),
        .gz_out          (gz_o),
        .valid_out       (valid_o),
        .busy_out        (busy_o),
        .cal_done_out    (done_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks how many samples have arrived since the last start: the first S are
    // discarded, the next N are summed, then one cycle later the floored mean loads.
    bit m_active, m_div, m_done, m_valid;
    int m_seen;
    int m_sum [3];
    int m_bias[3];
    int m_out [3];

    function automatic int ref_correct(input int raw, input int bias);
        int d;
        d = raw - bias;
        if (d > 32767)  d = 32767;
        if (d < -32768) d = -32768;
`ifdef GYRO_DEADBAND_EN
        if (d > -DB && d < DB) d = 0;
`else
`endif
        return d;
    endfunction

    function automatic int floor_div(input int s, input int n);
        if (s >= 0) return s / n;
        return -((-s + n - 1) / n);
    endfunction

    task automatic model_reset();
        m_active = 0; m_div = 0; m_done = 0; m_valid = 0; m_seen = 0;
        for (int a = 0; a < 3; a++) begin
            m_sum[a] = 0; m_bias[a] = 0; m_out[a] = 0;
        end
    endtask

    task automatic model_step(input bit sv, input int x, input int y, input int z, input bit st);
        int v[3];
        v[0] = x; v[1] = y; v[2] = z;
        m_valid = sv;
        if (sv) for (int a = 0; a < 3; a++) m_out[a] = ref_correct(v[a], m_bias[a]);
        if (m_div) begin
            for (int a = 0; a < 3; a++) m_bias[a] = floor_div(m_sum[a], N);
            m_done = 1; m_div = 0;
        end else if (st) begin
            m_active = 1; m_seen = 0; m_done = 0;
            for (int a = 0; a < 3; a++) m_sum[a] = 0;
        end else if (m_active && sv) begin
            if (m_seen >= S) for (int a = 0; a < 3; a++) m_sum[a] += v[a];
            m_seen++;
            if (m_seen == S + N) begin
                m_active = 0; m_div = 1;
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".valid"}, int'(valid_o), int'(m_valid));
        chk({tag, ".gx"}, int'(gx_o), m_out[0]);
        chk({tag, ".gy"}, int'(gy_o), m_out[1]);
        chk({tag, ".gz"}, int'(gz_o), m_out[2]);
        chk({tag, ".busy"}, int'(busy_o), int'(m_active | m_div));
        chk({tag, ".done"}, int'(done_o), int'(m_done));
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare against the model.
    task automatic step(input bit sv, input int x, input int y, input int z, input bit st);
        sample_valid = sv;
        gx = 16'(x); gy = 16'(y); gz = 16'(z);
        cal_start = st;
        @(posedge clk);
        #1;
        model_step(sv, x, y, z, st);
        check_model("step");
    endtask

    // Assert reset away from any edge, check outputs clear immediately, release on a falling edge.
    task automatic do_reset(input string tag);
        sample_valid = 0; cal_start = 0;
        rst_n = 0;
        #2;
        chk({tag, ".gx"}, int'(gx_o), 0);
        chk({tag, ".gy"}, int'(gy_o), 0);
        chk({tag, ".gz"}, int'(gz_o), 0);
        chk({tag, ".valid"}, int'(valid_o), 0);
        chk({tag, ".busy"}, int'(busy_o), 0);
        chk({tag, ".done"}, int'(done_o), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic calibrate(input int x, input int y, input int z);
        step(0, 0, 0, 0, 1);
        repeat (S) step(1, -7, 7, -7, 0);
        repeat (N) step(1, x, y, z, 0);
        step(0, 0, 0, 0, 0);
    endtask

    function automatic int rnd16();
        int r;
        r = int'($urandom_range(0, 7));
        if (r == 0) return -32768;
        if (r == 1) return 32767;
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    typedef struct {
        bit rst;
        bit sv;
        int gx;
        bit st;
        int exp_gx;
        bit exp_valid;
        bit exp_busy;
        bit exp_done;
    } vec_t;

    vec_t tbl[$];

    initial begin
        model_reset();

        // No calibration: pass-through with valid one cycle after each strobe.
        for (int i = 0; i < 5; i++) begin
            tbl.push_back('{0, 1, 100, 0, 100, 1, 0, 0});
            tbl.push_back('{0, 0, 0,   0, 100, 0, 0, 0});
        end
        // Calibration: two settle samples dropped, mean of 10,12,14,16 = 13.
        tbl.push_back('{0, 0, 0,   1, 100, 0, 1, 0});
        tbl.push_back('{0, 1, 999, 0, 999, 1, 1, 0});
        tbl.push_back('{0, 1, 999, 0, 999, 1, 1, 0});
        tbl.push_back('{0, 1, 10,  0, 10,  1, 1, 0});
        tbl.push_back('{0, 1, 12,  0, 12,  1, 1, 0});
        tbl.push_back('{0, 1, 14,  0, 14,  1, 1, 0});
        tbl.push_back('{0, 1, 16,  0, 16,  1, 1, 0});
        tbl.push_back('{0, 0, 0,   0, 16,  0, 0, 1});
        tbl.push_back('{0, 1, 20,  0, 7,   1, 0, 1});
        // Deadband behaviour with zero bias.
        tbl.push_back('{1, 1, 3,   0, DB_P3, 1, 0, 0});
        tbl.push_back('{0, 1, -3,  0, DB_M3, 1, 0, 0});
        tbl.push_back('{0, 1, 4,   0, 4,     1, 0, 0});

        do_reset("reset0");

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset($sformatf("tbl%0d.rst", i));
            step(tbl[i].sv, tbl[i].gx, 0, 0, tbl[i].st);
            chk($sformatf("tbl%0d.gx", i), int'(gx_o), tbl[i].exp_gx);
            chk($sformatf("tbl%0d.valid", i), int'(valid_o), int'(tbl[i].exp_valid));
            chk($sformatf("tbl%0d.busy", i), int'(busy_o), int'(tbl[i].exp_busy));
            chk($sformatf("tbl%0d.done", i), int'(done_o), int'(tbl[i].exp_done));
        end

        // Saturation at both extremes.
        calibrate(-32768, 0, 0);
        chk("sat_hi.done", int'(done_o), 1);
        step(1, 32767, 0, 0, 0);
        chk("sat_hi.gx", int'(gx_o), 32767);
        calibrate(32767, 0, 0);
        step(1, -32768, 0, 0, 0);
        chk("sat_lo.gx", int'(gx_o), -32768);

        // Restart after 3 of 4 accumulated samples keeps the old bias until the new result.
        calibrate(40, 0, 0);
        step(0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        repeat (3) step(1, 100, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        chk("restart.busy", int'(busy_o), 1);
        chk("restart.done", int'(done_o), 0);
        step(1, 1000, 0, 0, 0);
        chk("restart.old_bias", int'(gx_o), 960);
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < N; i++) begin
            step(1, 200, 0, 0, 0);
            chk($sformatf("restart.acc%0d.busy", i), int'(busy_o), 1);
        end
        chk("restart.acc.gx", int'(gx_o), 160);
        step(0, 0, 0, 0, 0);
        chk("restart.new_done", int'(done_o), 1);
        step(1, 1000, 0, 0, 0);
        chk("restart.new_bias", int'(gx_o), 800);

        // Asynchronous reset in the middle of accumulation.
        step(0, 0, 0, 0, 1);
        step(1, 5, 5, 5, 0);
        step(1, 5, 5, 5, 0);
        step(1, 300, 400, 500, 0);
        step(1, 300, 400, 500, 0);
        #2;
        do_reset("midrst");
        step(1, 300, 400, 500, 0);
        chk("midrst.after.gx", int'(gx_o), 300);
        chk("midrst.after.done", int'(done_o), 0);

        // Randomized traffic against the model.
        do_reset("rand.rst");
        for (int i = 0; i < 4000; i++) begin
            step(bit'($urandom_range(0, 1)), rnd16(), rnd16(), rnd16(),
                 $urandom_range(0, 39) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gyro_calib_ctrl.md
GYRO_CALIB_CTRL -- requirements
Module: gyro_calib_ctrl

Interface
REQ-001 Parameter LOG2_SAMPLES, default 8, sets calibration sample count N = 2^LOG2_SAMPLES.
REQ-002 Parameter SETTLE_SAMPLES, default 16, sets the number of samples discarded before accumulation.
REQ-003 Parameter DEADBAND, default 4, sets the magnitude threshold used when the deadband feature is compiled in.
REQ-004 clk_in  input  1  system clock (100 MHz domain).
REQ-005 rst_n_in  input  1  reset; one clock, asynchronous and active-low.
REQ-006 sample_valid_in  input  1  one-cycle strobe marking a new gyro sample on gx_in/gy_in/gz_in.
REQ-007 gx_in, gy_in, gz_in  input  16 each  signed raw gyro rates.
REQ-008 cal_start_in  input  1  one-cycle request to (re)start calibration.
REQ-009 gx_out, gy_out, gz_out  output  16 each  signed bias-corrected rates.
REQ-010 valid_out  output  1  one-cycle strobe qualifying gx_out/gy_out/gz_out.
REQ-011 busy_out  output  1  high while in SETTLE, ACCUM or DIVIDE.
REQ-012 cal_done_out  output  1  high once a bias has been computed and not since invalidated.

Function
REQ-013 FSM states SHALL be IDLE, SETTLE, ACCUM, DIVIDE, RUN.
REQ-014 IDLE: on cal_start_in -> SETTLE, clear settle/sample counters and accumulators.
REQ-015 SETTLE: count sample_valid_in strobes; after SETTLE_SAMPLES strobes -> ACCUM; SETTLE_SAMPLES = 0 goes directly to ACCUM on the next cycle.
REQ-016 ACCUM: on each sample_valid_in, add sign-extended gx_in/gy_in/gz_in into three accumulators of width 16+LOG2_SAMPLES; after the N-th sample -> DIVIDE.
REQ-017 DIVIDE: one cycle; bias_x/y/z <= accumulator arithmetic-right-shifted by LOG2_SAMPLES (truncate toward minus infinity); cal_done_out <= 1; -> RUN.
REQ-018 RUN: remain until cal_start_in; cal_start_in in RUN -> SETTLE, cal_done_out <= 0, previous bias retained until the next DIVIDE.
REQ-019 cal_start_in during SETTLE or ACCUM SHALL restart at SETTLE with cleared counters and accumulators; ignored during DIVIDE.
REQ-020 cal_start_in coincident with sample_valid_in: restart wins, that sample is not counted.
REQ-021 In every state, a sample_valid_in produces valid_out exactly one cycle later with out = saturate16(in - bias), computed at 17 bits and clamped to [-32768, 32767].
REQ-022 Outputs SHALL hold their last value between valid_out strobes.
REQ-023 Samples arriving while in DIVIDE use the old bias for correction and are not accumulated.
REQ-024 busy_out and cal_done_out are registered and state-decoded with no extra latency.

Reset
REQ-025 While rst_n_in is low: state = IDLE, bias = 0, accumulators/counters = 0, all outputs = 0.
REQ-026 Reset mid-calibration SHALL abandon it; cal_done_out = 0 after reset.
REQ-027 Reset deassertion takes effect on the first clk_in edge it is released for; no samples are lost except those in the reset window.

Configuration
REQ-028 Macro GYRO_DEADBAND_EN: when defined, any corrected value with |value| < DEADBAND SHALL be output as 0; when undefined, no deadband logic exists and REQ-021 applies unmodified.

Verification
REQ-029 Reset, then 5 samples gx=100 with no calibration -> gx_out=100 each, valid_out one cycle after each strobe, cal_done_out=0.
REQ-030 LOG2_SAMPLES=2, SETTLE_SAMPLES=2: cal_start, samples gx = 999, 999, then 10, 12, 14, 16 -> bias_x=13, cal_done_out=1 one cycle after DIVIDE; next gx_in=20 -> gx_out=7.
REQ-031 Bias=-32768 equivalent (accumulate gx=-32768) then gx_in=32767 -> gx_out=32767 (saturated); bias=+32767 with gx_in=-32768 -> gx_out=-32768.
REQ-032 cal_start after 3 of 4 ACCUM samples -> counters cleared, busy_out stays high, bias from the first run unchanged until the new DIVIDE completes.
REQ-033 rst_n_in pulsed low asynchronously during ACCUM -> all outputs 0 immediately, state IDLE, cal_done_out=0.
REQ-034 With GYRO_DEADBAND_EN, DEADBAND=4, bias=0: gx_in = 3, -3, 4 -> gx_out = 0, 0, 4; without it -> 3, -3, 4.
